grid_scanner: RTL and testbench
===============================

Name: grid_scanner

Overview:
- Parametrised raster generator for the game board.
- Walks every cell of a GRID_W x GRID_H board in row-major order and presents (x, y) plus a registered border flag to the image generator over a valid/ready handshake.
- Emits frame start/end markers.
- Supports single-shot and continuous refresh with a programmable inter-frame gap.
- Replaces the fixed 16x12 combinational border decode used at the top level.

Parameters:
- GRID_W, 16, board width in cells (>= 2)
- GRID_H, 12, board height in cells (>= 2)
- XW, 4, width of x output; must satisfy 2^XW >= GRID_W
- YW, 4, width of y output; must satisfy 2^YW >= GRID_H
- FRAME_GAP, 4, idle cycles between frames in continuous mode (0 allowed)

Ports:
- clk  input  1  system clock
- nrst  input  1  synchronous active-low reset
- enable  input  1  0 = freeze all state; valid forced low while frozen
- start  input  1  begin a frame when IDLE; ignored otherwise
- cont  input  1  1 = restart automatically after each frame
- abort  input  1  drop current frame, return to IDLE
- ready  input  1  downstream accepts the current cell
- valid  output  1  x/y/border/first/last are meaningful
- x  output  XW  cell column, 0..GRID_W-1
- y  output  YW  cell row, 0..GRID_H-1
- border  output  1  x==0 or x==GRID_W-1 or y==0 or y==GRID_H-1
- first  output  1  current cell is (0,0)
- last  output  1  current cell is (GRID_W-1, GRID_H-1)
- frame_done  output  1  one-cycle pulse after the last cell is accepted
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (nrst), sampled on the rising edge of clk.
- Reset values: state=IDLE, x=0, y=0, valid=0, border=1 (the (0,0) value), first=1, last=0, frame_done=0, busy=0, gap counter=0.
- Derived outputs: border, first and last are always consistent with the current x/y, whether or not valid is high.
- States: IDLE, SCAN, GAP.
- IDLE:
  - When enable && start, go to SCAN the next cycle with x=0, y=0, valid=1.
  - Start-to-first-valid latency is 1 cycle.
- SCAN:
  - valid=1 whenever enable=1.
  - Transfer occurs when valid && ready.
  - While valid && !ready, x/y/border/first/last hold stable.
  - On a transfer, x increments. At x==GRID_W-1, x goes to 0 and y increments.
  - No output value ever exceeds GRID_W-1 / GRID_H-1, including for non-power-of-2 grids.
- Transfer of the last cell:
  - x and y go to 0, and frame_done=1 for exactly the next cycle.
  - If cont=1 and FRAME_GAP>0: go to GAP with counter=FRAME_GAP, valid=0.
  - If cont=1 and FRAME_GAP==0: stay in SCAN; valid stays 1 and the next frame's (0,0) is presented in the same cycle frame_done pulses.
  - If cont=0: go to IDLE, valid=0.
- GAP:
  - Counter decrements each enabled cycle.
  - After exactly FRAME_GAP cycles with valid=0, enter SCAN.
  - cont is sampled at the last-cell transfer only.
- abort:
  - Highest priority after reset, from any state.
  - Next cycle: IDLE, x=y=0, valid=0, no frame_done.
  - abort coincident with the last-cell transfer also suppresses frame_done.
- enable=0:
  - valid=0; state, counters and x/y hold; ready is ignored.
  - A pending frame_done pulse still clears after one cycle.
  - Resuming continues from the held cell.
- start: ignored outside IDLE, and ignored while enable=0.
- Reset mid-frame: IDLE next cycle with reset values, no frame_done.

Optional Feature:
- Macro: GRID_SCANNER_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt [15:0], reset to 0.
  - Increments in the cycle frame_done is asserted; wraps 0xFFFF->0.
  - Unaffected by abort and enable.
- When not defined: port and counter are absent. All other behaviour is identical.

Test Plan:
- GRID_W=4, GRID_H=3, ready=1, start pulse, cont=0 -> valid for exactly 12 cycles. Sequence (0,0),(1,0)..(3,0),(0,1)..(3,2). border=0 only at (1,1) and (2,1). first at cycle 1, last at cycle 12. frame_done one cycle later, then busy=0.
- Same grid, ready toggling 1,0,0,1 pattern -> x/y stable during every ready=0 cycle. Still exactly 12 transfers, then one frame_done.
- cont=1, FRAME_GAP=3 -> after frame_done, valid low for exactly 3 cycles, then (0,0) again. With FRAME_GAP=0 -> valid never drops and frame_done coincides with (0,0).
- abort asserted at cell (2,1); separately abort on the same cycle as the last transfer -> IDLE next cycle, x=y=0, frame_done never pulses.
- enable=0 for 5 cycles at cell (3,0); nrst low at cell (1,2) -> freeze holds (3,0) with valid=0, then resumes to (0,1). Reset yields reset values next cycle and ignores a start in the same cycle.
- With GRID_SCANNER_FRAME_CNT_EN: preload to 0xFFFE via 2 frames after forcing, or run 3 continuous frames -> frame_cnt=3. Wrap from 0xFFFF to 0 on the next frame_done.

Source files
------------

// File: rtl/grid_scanner.sv
// grid_scanner: raster generator for the game board.
//
// Walks every cell of a GRID_W x GRID_H board in row-major order and presents
// (x, y) with registered border/first/last flags over a valid/ready handshake.
// Frames run single-shot or continuously, with FRAME_GAP idle cycles between frames.
//
// Optional feature: define GRID_SCANNER_FRAME_CNT_EN to add a 16-bit frame counter
// output (frame_cnt) that increments with every frame_done pulse.
//
// Ports:
//   clk        system clock
//   nrst       synchronous active-low reset
//   enable     0 freezes all state; valid is forced low while frozen
//   start      begin a frame when idle
//   cont       restart automatically after each frame (sampled at the last transfer)
//   abort      drop the current frame and return to idle
//   ready      downstream accepts the current cell
//   valid      x/y/border/first/last are meaningful
//   x, y       current cell column / row
//   border     cell lies on the board edge
//   first      cell is (0,0)
//   last       cell is (GRID_W-1, GRID_H-1)
//   frame_done one-cycle pulse after the last cell is accepted
//   busy       scanner is not idle
//   frame_cnt  completed-frame count (GRID_SCANNER_FRAME_CNT_EN only)
module grid_scanner #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 12,
  parameter int XW        = 4,
  parameter int YW        = 4,
  parameter int FRAME_GAP = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          enable,
  input  logic          start,
  input  logic          cont,
  input  logic          abort,
  input  logic          ready,
  output logic          valid,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          border,
  output logic          first,
  output logic          last,
  output logic          frame_done,
  output logic          busy
`ifdef GRID_SCANNER_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam logic [XW-1:0] XMax    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMax    = YW'(GRID_H - 1);
  localparam int            GapW    = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
  localparam logic [GapW-1:0] GapInit = GapW'(FRAME_GAP);

  typedef enum logic [1:0] {StIdle, StScan, StGap} state_e;

  state_e          r_state;
  logic            r_valid;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_border;
  logic            r_first;
  logic            r_last;
  logic            r_frame_done;
  logic            r_busy;
  logic [GapW-1:0] r_gap_cnt;
`ifdef GRID_SCANNER_FRAME_CNT_EN
  logic [15:0]     r_frame_cnt;
`endif

  logic          w_at_xmax;
  logic          w_at_last;
  logic [XW-1:0] w_x_adv;
  logic [YW-1:0] w_y_adv;

  function automatic logic f_border(input logic [XW-1:0] fx, input logic [YW-1:0] fy);
    return (fx == '0) || (fx == XMax) || (fy == '0) || (fy == YMax);
  endfunction

  // Coordinates after accepting the current cell; the last cell wraps to (0,0).
  always_comb begin
    w_at_xmax = (r_x == XMax);
    w_at_last = w_at_xmax && (r_y == YMax);
    w_x_adv   = w_at_xmax ? '0 : r_x + XW'(1);
    w_y_adv   = w_at_last ? '0 : (w_at_xmax ? r_y + YW'(1) : r_y);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= StIdle;
      r_valid      <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_border     <= 1'b1;
      r_first      <= 1'b1;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_gap_cnt    <= '0;
`ifdef GRID_SCANNER_FRAME_CNT_EN
      r_frame_cnt  <= '0;
`endif
    end else begin
      // The pulse always clears after one cycle, even while frozen.
      r_frame_done <= 1'b0;
      if (abort) begin
        r_state   <= StIdle;
        r_valid   <= 1'b0;
        r_x       <= '0;
        r_y       <= '0;
        r_border  <= 1'b1;
        r_first   <= 1'b1;
        r_last    <= 1'b0;
        r_busy    <= 1'b0;
        r_gap_cnt <= '0;
      end else if (enable) begin
        unique case (r_state)
          StIdle: begin
            if (start) begin
              r_state <= StScan;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          StScan: begin
            r_valid <= 1'b1;
            if (r_valid && ready) begin
              r_x      <= w_x_adv;
              r_y      <= w_y_adv;
              r_border <= f_border(w_x_adv, w_y_adv);
              r_first  <= (w_x_adv == '0) && (w_y_adv == '0);
              r_last   <= (w_x_adv == XMax) && (w_y_adv == YMax);
              if (w_at_last) begin
                r_frame_done <= 1'b1;
`ifdef GRID_SCANNER_FRAME_CNT_EN
                r_frame_cnt  <= r_frame_cnt + 16'd1;
`endif
                if (!cont) begin
                  r_state <= StIdle;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                end else if (FRAME_GAP > 0) begin
                  r_state   <= StGap;
                  r_valid   <= 1'b0;
                  r_gap_cnt <= GapInit;
                end
                // cont with no gap: stay in scan, (0,0) is presented immediately.
              end
            end
          end
          StGap: begin
            if (r_gap_cnt <= GapW'(1)) begin
              r_state   <= StScan;
              r_valid   <= 1'b1;
              r_gap_cnt <= '0;
            end else begin
              r_gap_cnt <= r_gap_cnt - GapW'(1);
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // valid is gated by enable so a freeze drops it in the same cycle.
  assign valid      = r_valid && enable;
  assign x          = r_x;
  assign y          = r_y;
  assign border     = r_border;
  assign first      = r_first;
  assign last       = r_last;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
`ifdef GRID_SCANNER_FRAME_CNT_EN
  assign frame_cnt  = r_frame_cnt;
`endif

endmodule

// File: tb/tb_grid_scanner.sv
// Self-checking bench for grid_scanner: a 4x3 board with FRAME_GAP=3 (dut 0) and
// FRAME_GAP=0 (dut 1) driven by the same stimulus, compared every cycle against a
// cell-index reference model.
module tb_grid_scanner;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int VW = 11;

  logic clk = 1'b0;
  logic nrst = 1'b0, enable = 1'b0, start = 1'b0, cont = 1'b0, abort = 1'b0, ready = 1'b0;

  logic       valid0, border0, first0, last0, fd0, busy0;
  logic [2:0] x0;
  logic [1:0] y0;
  logic       valid1, border1, first1, last1, fd1, busy1;
  logic [2:0] x1;
  logic [1:0] y1;
`ifdef GRID_SCANNER_FRAME_CNT_EN
  logic [15:0] fcnt0, fcnt1;
`endif

  always #5 clk = ~clk;

  grid_scanner #(.GRID_W(W), .GRID_H(H), .XW(3), .YW(2), .FRAME_GAP(3)) u_dut0 (
    .clk(clk), .nrst(nrst), .enable(enable), .start(start), .cont(cont), .abort(abort),
    .ready(ready), .valid(valid0), .x(x0), .y(y0), .border(border0), .first(first0),
    .last(last0), .frame_done(fd0), .busy(busy0)
`ifdef GRID_SCANNER_FRAME_CNT_EN
    , .frame_cnt(fcnt0)
`endif
  );

  grid_scanner #(.GRID_W(W), .GRID_H(H), .XW(3), .YW(2), .FRAME_GAP(0)) u_dut1 (
    .clk(clk), .nrst(nrst), .enable(enable), .start(start), .cont(cont), .abort(abort),
    .ready(ready), .valid(valid1), .x(x1), .y(y1), .border(border1), .first(first1),
    .last(last1), .frame_done(fd1), .busy(busy1)
`ifdef GRID_SCANNER_FRAME_CNT_EN
    , .frame_cnt(fcnt1)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 scanning, 2 gap; idx is the row-major cell index.
  int m_phase[2];
  int m_idx[2];
  int m_gap[2];
  int m_fd[2];
  int m_cnt[2];
  int gaps[2] = '{3, 0};

  function automatic logic [VW-1:0] exp_vec(input int k);
    int ex, ey;
    logic bd, fi, la;
    ex = m_idx[k] % W;
    ey = m_idx[k] / W;
    bd = (ex == 0) || (ex == W - 1) || (ey == 0) || (ey == H - 1);
    fi = (m_idx[k] == 0);
    la = (m_idx[k] == N - 1);
    return {(m_phase[k] == 1) && enable, 3'(ex), 2'(ey), bd, fi, la, m_fd[k] != 0,
            m_phase[k] != 0};
  endfunction

  function automatic logic [VW-1:0] obs_vec(input int k);
    if (k == 0) return {valid0, x0, y0, border0, first0, last0, fd0, busy0};
    return {valid1, x1, y1, border1, first1, last1, fd1, busy1};
  endfunction

  task automatic tick(input logic rn, input logic en, input logic st, input logic ct,
                      input logic ab, input logic rd);
    nrst = rn; enable = en; start = st; cont = ct; abort = ab; ready = rd;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_fd[k] = 0;
      if (!rn) begin
        m_phase[k] = 0; m_idx[k] = 0; m_gap[k] = 0; m_cnt[k] = 0;
      end else if (ab) begin
        m_phase[k] = 0; m_idx[k] = 0; m_gap[k] = 0;
      end else if (en) begin
        if (m_phase[k] == 0) begin
          if (st) begin m_phase[k] = 1; m_idx[k] = 0; end
        end else if (m_phase[k] == 1) begin
          if (rd) begin
            if (m_idx[k] == N - 1) begin
              m_idx[k] = 0;
              m_fd[k] = 1;
              m_cnt[k] = (m_cnt[k] + 1) % 65536;
              if (!ct) m_phase[k] = 0;
              else if (gaps[k] > 0) begin m_phase[k] = 2; m_gap[k] = gaps[k]; end
            end else begin
              m_idx[k] = m_idx[k] + 1;
            end
          end
        end else begin
          m_gap[k] = m_gap[k] - 1;
          if (m_gap[k] == 0) m_phase[k] = 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_errors++;
          $display("FAIL reset[%0d] dut%0d: got %b want %b", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_single_frame();
    int nvalid = 0;
    int nfd = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b1, i == 0, 1'b0, 1'b0, 1'b1);
      if (valid0) nvalid++;
      if (fd0) nfd++;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_errors++;
          $display("FAIL single[%0d] dut%0d: got %b want %b", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
    n_checks++;
    if (nvalid !== N || nfd !== 1) begin
      n_errors++;
      $display("FAIL single_count: got valid=%0d done=%0d want valid=%0d done=1",
               nvalid, nfd, N);
    end
  endtask

  task automatic test_backpressure();
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int xfers = 0;
    int nfd = 0;
    int i = 0;
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    while (busy0 && i < 80) begin
      if (valid0 && pat[i % 4]) xfers++;
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pat[i % 4]);
      if (fd0) nfd++;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_errors++;
          $display("FAIL backpressure[%0d] dut%0d: got %b want %b", i, k, obs_vec(k),
                   exp_vec(k));
        end
      end
      i++;
    end
    n_checks++;
    if (xfers !== N || nfd !== 1 || busy0 !== 1'b0) begin
      n_errors++;
      $display("FAIL backpressure_count: got xfers=%0d done=%0d busy=%b want %0d/1/0",
               xfers, nfd, busy0, N);
    end
  endtask

  task automatic test_continuous();
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 1'b1, i == 0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_errors++;
          $display("FAIL continuous[%0d] dut%0d: got %b want %b", i, k, obs_vec(k),
                   exp_vec(k));
        end
      end
    end
`ifdef GRID_SCANNER_FRAME_CNT_EN
    n_checks++;
    if (fcnt0 !== 16'(m_cnt[0]) || fcnt1 !== 16'(m_cnt[1])) begin
      n_errors++;
      $display("FAIL frame_cnt: got %0d/%0d want %0d/%0d", fcnt0, fcnt1, m_cnt[0], m_cnt[1]);
    end
`endif
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_errors++;
        $display("FAIL continuous_abort dut%0d: got %b want %b", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  // Abort at cell (2,1), then abort coincident with the last transfer.
  task automatic test_abort();
    int target[2] = '{6, N - 1};
    for (int t = 0; t < 2; t++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < target[t]; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
        tick(1'b1, 1'b1, 1'b0, 1'b0, i == 0, 1'b1);
        for (int k = 0; k < 2; k++) begin
          n_checks++;
          if (obs_vec(k) !== exp_vec(k)) begin
            n_errors++;
            $display("FAIL abort%0d[%0d] dut%0d: got %b want %b", t, i, k, obs_vec(k),
                     exp_vec(k));
          end
        end
      end
    end
  endtask

  // Freeze at (3,0) for five cycles, then resume.
  task automatic test_freeze();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      tick(1'b1, !(i < 5), 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_errors++;
          $display("FAIL freeze[%0d] dut%0d: got %b want %b", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  // Reset at (1,2) with a coincident start, then idle.
  task automatic test_reset_mid();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(i != 0, 1'b1, i == 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_errors++;
          $display("FAIL reset_mid[%0d] dut%0d: got %b want %b", i, k, obs_vec(k),
                   exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_errors++;
          $display("FAIL random[%0d] dut%0d: got %b want %b", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
`ifdef GRID_SCANNER_FRAME_CNT_EN
    n_checks++;
    if (fcnt0 !== 16'(m_cnt[0]) || fcnt1 !== 16'(m_cnt[1])) begin
      n_errors++;
      $display("FAIL random_frame_cnt: got %0d/%0d want %0d/%0d", fcnt0, fcnt1, m_cnt[0],
               m_cnt[1]);
    end
`endif
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_idx[k] = 0; m_gap[k] = 0; m_fd[k] = 0; m_cnt[k] = 0;
    end
    test_reset();
    test_single_frame();
    test_backpressure();
    test_continuous();
    test_abort();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
